aes_core_arbiter: RTL and testbench

Sequencer and round-robin arbiter that shares one combinational AES-128 encrypt/decrypt core between two requesters. It registers each accepted job (data, key, mode) onto the core inputs and holds them for a fixed multicycle settle window. It then captures the selected core output and returns it to the owning requester over a valid/ready response channel. It sits between the two client ports and the AES datapath, which stays purely combinational.

---
 rtl/aes_ctrl_pkg.sv | 25 ++
 rtl/aes_rr_arb2.sv | 14 +
 rtl/aes_core_arbiter.sv | 138 +++++++++++++
 tb/tb_aes_core_arbiter.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the shared-AES-core controllers.
package aes_ctrl_pkg;

    localparam int AES_W = 128;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Two-way round robin: a lone requester always wins, a tie (or nobody) goes
    // to the requester that was not granted last.
    function automatic logic rr_pick(input logic [1:0] valid, input logic last_grant);
        case (valid)
            2'b01:   return 1'b0;
            2'b10:   return 1'b1;
            default: return ~last_grant;
        endcase
    endfunction

endpackage

// File: rtl/aes_rr_arb2.sv
// Two-way round-robin chooser shared by the shared-core controllers.
module aes_rr_arb2
    import aes_ctrl_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic       sel
);

    always_comb begin
        sel = rr_pick(valid, last_grant);
    end

endmodule

// File: rtl/aes_core_arbiter.sv
// Sequences jobs from two requesters through one shared combinational AES core.
//   state | meaning
//   IDLE  | arbitrating; ready raised toward the selected valid requester
//   WAIT  | core inputs held while the combinational core settles
//   RESP  | captured result offered to the owning requester
module aes_core_arbiter
    import aes_ctrl_pkg::*;
#(
    parameter int CORE_WAIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic             req0_mode,
    input  logic [AES_W-1:0] req0_data,
    input  logic [AES_W-1:0] req0_key,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic             req1_mode,
    input  logic [AES_W-1:0] req1_data,
    input  logic [AES_W-1:0] req1_key,
    output logic [AES_W-1:0] core_data,
    output logic [AES_W-1:0] core_key,
    input  logic [AES_W-1:0] core_enc_out,
    input  logic [AES_W-1:0] core_dec_out,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [AES_W-1:0] rsp_data,
    output logic             busy,
    output logic             owner,
    output logic [15:0]      jobs_done
);

    localparam logic [3:0] CNT_LAST = 4'(CORE_WAIT - 1);

    state_e           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             owner_q, owner_d;
    logic             mode_q, mode_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [AES_W-1:0] core_data_q, core_data_d;
    logic [AES_W-1:0] core_key_q, core_key_d;
    logic [AES_W-1:0] rsp_data_q, rsp_data_d;
    logic [15:0]      jobs_done_q, jobs_done_d;

    logic sel;
    logic accept;
    logic rsp_take;

    aes_rr_arb2 u_arb (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_grant_q),
        .sel        (sel)
    );

    // Ready depends only on state, valids and last grant, never on a response ready.
    assign req0_ready = (state_q == IDLE) && req0_valid && (sel == 1'b0);
    assign req1_ready = (state_q == IDLE) && req1_valid && (sel == 1'b1);
    assign accept     = req0_ready || req1_ready;
    assign rsp_take   = owner_q ? rsp1_ready : rsp0_ready;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        mode_d       = mode_q;
        cnt_d        = cnt_q;
        core_data_d  = core_data_q;
        core_key_d   = core_key_q;
        rsp_data_d   = rsp_data_q;
        jobs_done_d  = jobs_done_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    core_data_d  = sel ? req1_data : req0_data;
                    core_key_d   = sel ? req1_key  : req0_key;
                    mode_d       = sel ? req1_mode : req0_mode;
                    owner_d      = sel;
                    last_grant_d = sel;
                    cnt_d        = 4'd0;
                    state_d      = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == CNT_LAST) begin
                    rsp_data_d = (mode_q == MODE_DEC) ? core_dec_out : core_enc_out;
                    state_d    = RESP;
                end
            end
            RESP: begin
                if (rsp_take) begin
                    jobs_done_d = jobs_done_q + 16'd1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            mode_q       <= MODE_ENC;
            cnt_q        <= 4'd0;
            core_data_q  <= '0;
            core_key_q   <= '0;
            rsp_data_q   <= '0;
            jobs_done_q  <= 16'd0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            mode_q       <= mode_d;
            cnt_q        <= cnt_d;
            core_data_q  <= core_data_d;
            core_key_q   <= core_key_d;
            rsp_data_q   <= rsp_data_d;
            jobs_done_q  <= jobs_done_d;
        end
    end

    assign core_data  = core_data_q;
    assign core_key   = core_key_q;
    assign rsp_data   = rsp_data_q;
    assign owner      = owner_q;
    assign jobs_done  = jobs_done_q;
    assign busy       = (state_q != IDLE);
    assign rsp0_valid = (state_q == RESP) && (owner_q == 1'b0);
    assign rsp1_valid = (state_q == RESP) && (owner_q == 1'b1);

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Bench for aes_core_arbiter with a behavioural AES-128 core and job-level reference model.
module tb_aes_core_arbiter;

    localparam int CW = 2;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic clk = 1'b0;
    logic rst;
    logic req0_valid, req0_ready, req0_mode, req1_valid, req1_ready, req1_mode;
    logic [127:0] req0_data, req0_key, req1_data, req1_key;
    logic [127:0] core_data, core_key, core_enc_out, core_dec_out, rsp_data;
    logic rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready, busy, owner;
    logic [15:0] jobs_done;

    int n_vec = 0;
    int n_err = 0;
    logic m_last;
    logic [15:0] m_jobs;

    always #5 clk = ~clk;

    aes_core_arbiter #(.CORE_WAIT(CW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_mode(req0_mode),
        .req0_data(req0_data), .req0_key(req0_key),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_mode(req1_mode),
        .req1_data(req1_data), .req1_key(req1_key),
        .core_data(core_data), .core_key(core_key),
        .core_enc_out(core_enc_out), .core_dec_out(core_dec_out),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_data(rsp_data), .busy(busy), .owner(owner), .jobs_done(jobs_done)
    );

    // ---------------- behavioural AES-128 ----------------
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b);
        logic [7:0] p, a;
        p = 8'h00;
        a = a_in;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = xt(a);
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] r, p;
        r = 8'h01;
        p = x;
        for (int i = 1; i < 8; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rl(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = ginv(x);
        return b ^ rl(b, 1) ^ rl(b, 2) ^ rl(b, 3) ^ rl(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] isbox(input logic [7:0] y);
        return ginv(rl(y, 1) ^ rl(y, 3) ^ rl(y, 6) ^ 8'h05);
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] x, input logic inv);
        logic [127:0] y;
        for (int i = 0; i < 16; i++)
            y[127-8*i -: 8] = inv ? isbox(x[127-8*i -: 8]) : sbox(x[127-8*i -: 8]);
        return y;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] x, input logic inv);
        logic [127:0] y;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                if (!inv) y[127-8*(r+4*c) -: 8] = x[127-8*(r+4*((c+r)%4)) -: 8];
                else      y[127-8*(r+4*((c+r)%4)) -: 8] = x[127-8*(r+4*c) -: 8];
            end
        return y;
    endfunction

    function automatic logic [127:0] mix_cols(input logic [127:0] x, input logic inv);
        logic [127:0] y;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = x[127-8*(4*c) -: 8];
            a1 = x[127-8*(4*c+1) -: 8];
            a2 = x[127-8*(4*c+2) -: 8];
            a3 = x[127-8*(4*c+3) -: 8];
            if (!inv) begin
                y[127-8*(4*c) -: 8]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                y[127-8*(4*c+1) -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                y[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                y[127-8*(4*c+3) -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end else begin
                y[127-8*(4*c) -: 8]   = gmul(a0, 8'd14) ^ gmul(a1, 8'd11) ^ gmul(a2, 8'd13) ^ gmul(a3, 8'd9);
                y[127-8*(4*c+1) -: 8] = gmul(a0, 8'd9) ^ gmul(a1, 8'd14) ^ gmul(a2, 8'd11) ^ gmul(a3, 8'd13);
                y[127-8*(4*c+2) -: 8] = gmul(a0, 8'd13) ^ gmul(a1, 8'd9) ^ gmul(a2, 8'd14) ^ gmul(a3, 8'd11);
                y[127-8*(4*c+3) -: 8] = gmul(a0, 8'd11) ^ gmul(a1, 8'd13) ^ gmul(a2, 8'd9) ^ gmul(a3, 8'd14);
            end
        end
        return y;
    endfunction

    function automatic logic [127:0] next_rk(input logic [127:0] k, input logic [7:0] rcon);
        logic [31:0] w0, w1, w2, w3, t;
        {w0, w1, w2, w3} = k;
        t = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rcon, 24'h0};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
        logic [127:0] s, k;
        logic [7:0] rc;
        s  = pt ^ key;
        k  = key;
        rc = 8'h01;
        for (int r = 1; r <= 10; r++) begin
            k  = next_rk(k, rc);
            rc = xt(rc);
            s  = shift_rows(sub_bytes(s, 1'b0), 1'b0);
            if (r != 10) s = mix_cols(s, 1'b0);
            s = s ^ k;
        end
        return s;
    endfunction

    function automatic logic [127:0] aes_dec(input logic [127:0] ct, input logic [127:0] key);
        logic [127:0] rk [11];
        logic [127:0] s;
        logic [7:0] rc;
        rk[0] = key;
        rc = 8'h01;
        for (int r = 1; r <= 10; r++) begin
            rk[r] = next_rk(rk[r-1], rc);
            rc = xt(rc);
        end
        s = ct ^ rk[10];
        for (int r = 9; r >= 0; r--) begin
            s = sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ rk[r];
            if (r != 0) s = mix_cols(s, 1'b1);
        end
        return s;
    endfunction

    assign core_enc_out = aes_enc(core_data, core_key);
    assign core_dec_out = aes_dec(core_data, core_key);

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [127:0] expect_result(input logic m, input logic [127:0] d, input logic [127:0] k);
        return m ? aes_dec(d, k) : aes_enc(d, k);
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        req0_mode = 1'b0; req1_mode = 1'b0;
        req0_data = '0; req0_key = '0; req1_data = '0; req1_key = '0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_vec++; if (owner !== 1'b0) begin n_err++; $display("FAIL reset_owner got %b want 0", owner); end
        n_vec++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin n_err++; $display("FAIL reset_rsp_valid got %b want 00", {rsp0_valid, rsp1_valid}); end
        n_vec++; if (core_data !== '0) begin n_err++; $display("FAIL reset_core_data got %h want 0", core_data); end
        n_vec++; if (core_key !== '0) begin n_err++; $display("FAIL reset_core_key got %h want 0", core_key); end
        n_vec++; if (rsp_data !== '0) begin n_err++; $display("FAIL reset_rsp_data got %h want 0", rsp_data); end
        n_vec++; if (jobs_done !== 16'd0) begin n_err++; $display("FAIL reset_jobs_done got %h want 0", jobs_done); end
        rst = 1'b0;
        m_last = 1'b1;
        m_jobs = 16'd0;
    endtask

    task automatic test_fips_encrypt();
        @(negedge clk);
        req0_valid = 1'b1; req0_mode = 1'b0; req0_data = FIPS_PT; req0_key = FIPS_KEY;
        #1;
        n_vec++; if (req0_ready !== 1'b1) begin n_err++; $display("FAIL fips_req0_ready got %b want 1", req0_ready); end
        @(posedge clk);
        m_last = 1'b0;
        @(negedge clk); req0_valid = 1'b0; #1;
        n_vec++; if (core_data !== FIPS_PT) begin n_err++; $display("FAIL fips_core_data got %h want %h", core_data, FIPS_PT); end
        n_vec++; if (core_key !== FIPS_KEY) begin n_err++; $display("FAIL fips_core_key got %h want %h", core_key, FIPS_KEY); end
        n_vec++; if ({busy, rsp0_valid} !== 2'b10) begin n_err++; $display("FAIL fips_cycle1 busy/rsp0_valid got %b want 10", {busy, rsp0_valid}); end
        @(negedge clk); #1;
        n_vec++; if (rsp0_valid !== 1'b0) begin n_err++; $display("FAIL fips_cycle2_rsp0_valid got %b want 0", rsp0_valid); end
        @(negedge clk); #1;
        n_vec++; if ({rsp0_valid, rsp1_valid} !== 2'b10) begin n_err++; $display("FAIL fips_cycle3_valids got %b want 10", {rsp0_valid, rsp1_valid}); end
        n_vec++; if (rsp_data !== FIPS_CT) begin n_err++; $display("FAIL fips_rsp_data got %h want %h", rsp_data, FIPS_CT); end
        rsp0_ready = 1'b1;
        @(posedge clk);
        m_jobs++;
        @(negedge clk); rsp0_ready = 1'b0; #1;
        n_vec++; if (jobs_done !== m_jobs) begin n_err++; $display("FAIL fips_jobs_done got %h want %h", jobs_done, m_jobs); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL fips_idle_after_rsp got busy %b want 0", busy); end
    endtask

    task automatic test_decrypt();
        int lat;
        @(negedge clk);
        req1_valid = 1'b1; req1_mode = 1'b1; req1_data = FIPS_CT; req1_key = FIPS_KEY;
        #1;
        n_vec++; if ({req0_ready, req1_ready} !== 2'b01) begin n_err++; $display("FAIL dec_ready got %b want 01", {req0_ready, req1_ready}); end
        @(posedge clk);
        m_last = 1'b1;
        lat = 0;
        do begin
            @(negedge clk); req1_valid = 1'b0; #1;
            lat++;
            n_vec++; if (rsp0_valid !== 1'b0) begin n_err++; $display("FAIL dec_rsp0_valid got %b want 0", rsp0_valid); end
        end while (rsp1_valid !== 1'b1 && lat < 20);
        n_vec++; if (lat != CW + 1) begin n_err++; $display("FAIL dec_latency got %0d want %0d", lat, CW + 1); end
        n_vec++; if (rsp_data !== FIPS_PT) begin n_err++; $display("FAIL dec_rsp_data got %h want %h", rsp_data, FIPS_PT); end
        rsp1_ready = 1'b1;
        @(posedge clk);
        m_jobs++;
        @(negedge clk); rsp1_ready = 1'b0; #1;
        n_vec++; if (jobs_done !== m_jobs) begin n_err++; $display("FAIL dec_jobs_done got %h want %h", jobs_done, m_jobs); end
    endtask

    task automatic test_round_robin();
        logic [127:0] d [2];
        logic [127:0] k [2];
        logic md [2];
        logic want;
        logic [127:0] exp_rsp;
        for (int i = 0; i < 2; i++) begin
            d[i] = rnd128(); k[i] = rnd128(); md[i] = 1'($urandom_range(0, 1));
        end
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            rsp0_ready = 1'b0; rsp1_ready = 1'b0;
            req0_valid = 1'b1; req0_data = d[0]; req0_key = k[0]; req0_mode = md[0];
            req1_valid = 1'b1; req1_data = d[1]; req1_key = k[1]; req1_mode = md[1];
            #1;
            want = j[0];
            n_vec++; if ({req1_ready, req0_ready} !== (want ? 2'b10 : 2'b01)) begin n_err++; $display("FAIL rr_grant job %0d got %b want owner %0d", j, {req1_ready, req0_ready}, want); end
            exp_rsp = expect_result(md[want], d[want], k[want]);
            @(posedge clk);
            m_last = want;
            d[want] = rnd128(); k[want] = rnd128(); md[want] = 1'($urandom_range(0, 1));
            repeat (CW + 1) @(negedge clk);
            if (want) begin req1_data = d[1]; req1_key = k[1]; req1_mode = md[1]; end
            else      begin req0_data = d[0]; req0_key = k[0]; req0_mode = md[0]; end
            #1;
            n_vec++; if ({rsp1_valid, rsp0_valid} !== (want ? 2'b10 : 2'b01)) begin n_err++; $display("FAIL rr_rsp_valid job %0d got %b want owner %0d", j, {rsp1_valid, rsp0_valid}, want); end
            n_vec++; if (rsp_data !== exp_rsp) begin n_err++; $display("FAIL rr_rsp_data job %0d got %h want %h", j, rsp_data, exp_rsp); end
            n_vec++; if (owner !== want) begin n_err++; $display("FAIL rr_owner job %0d got %b want %b", j, owner, want); end
            if (want) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
            @(posedge clk);
            m_jobs++;
        end
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        #1;
        n_vec++; if (jobs_done !== m_jobs) begin n_err++; $display("FAIL rr_jobs_done got %h want %h", jobs_done, m_jobs); end
    endtask

    task automatic test_backpressure();
        logic [127:0] exp_rsp;
        @(negedge clk);
        req0_valid = 1'b1; req0_data = rnd128(); req0_key = rnd128(); req0_mode = 1'($urandom_range(0, 1));
        req1_valid = 1'b0;
        exp_rsp = expect_result(req0_mode, req0_data, req0_key);
        #1;
        n_vec++; if (req0_ready !== 1'b1) begin n_err++; $display("FAIL bp_req0_ready got %b want 1", req0_ready); end
        @(posedge clk);
        m_last = 1'b0;
        @(negedge clk); req0_valid = 1'b0;
        repeat (CW) @(negedge clk);
        req0_valid = 1'b1; req1_valid = 1'b1; rsp0_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            n_vec++; if ({rsp0_valid, rsp1_valid} !== 2'b10) begin n_err++; $display("FAIL bp_valid cycle %0d got %b want 10", i, {rsp0_valid, rsp1_valid}); end
            n_vec++; if (rsp_data !== exp_rsp) begin n_err++; $display("FAIL bp_rsp_data cycle %0d got %h want %h", i, rsp_data, exp_rsp); end
            n_vec++; if ({req0_ready, req1_ready} !== 2'b00) begin n_err++; $display("FAIL bp_req_ready cycle %0d got %b want 00", i, {req0_ready, req1_ready}); end
            n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL bp_busy cycle %0d got %b want 1", i, busy); end
            @(negedge clk);
        end
        rsp0_ready = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk);
        m_jobs++;
        @(negedge clk); rsp0_ready = 1'b0; #1;
        n_vec++; if ({busy, rsp0_valid} !== 2'b00) begin n_err++; $display("FAIL bp_release busy/rsp0_valid got %b want 00", {busy, rsp0_valid}); end
        n_vec++; if (jobs_done !== m_jobs) begin n_err++; $display("FAIL bp_jobs_done got %h want %h", jobs_done, m_jobs); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req0_valid = 1'b1; req0_data = rnd128(); req0_key = rnd128(); req0_mode = 1'b0;
        @(posedge clk);
        m_last = 1'b0;
        @(negedge clk); req0_valid = 1'b0; rst = 1'b1; #1;
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL rstmid_in_wait busy got %b want 1", busy); end
        @(posedge clk);
        @(negedge clk); rst = 1'b0; #1;
        m_jobs = 16'd0;
        m_last = 1'b1;
        n_vec++; if ({busy, owner, rsp0_valid, rsp1_valid} !== 4'b0000) begin n_err++; $display("FAIL rstmid_ctrl busy/owner/rsp_valids got %b want 0000", {busy, owner, rsp0_valid, rsp1_valid}); end
        n_vec++; if ({core_data, core_key, rsp_data} !== '0) begin n_err++; $display("FAIL rstmid_datapath got %h/%h/%h want zeros", core_data, core_key, rsp_data); end
        n_vec++; if (jobs_done !== 16'd0) begin n_err++; $display("FAIL rstmid_jobs_done got %h want 0", jobs_done); end
        req0_valid = 1'b1; req1_valid = 1'b1; #1;
        n_vec++; if ({req0_ready, req1_ready} !== 2'b10) begin n_err++; $display("FAIL rstmid_tie got %b want 10", {req0_ready, req1_ready}); end
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int i = 0; i < CW + 3; i++) begin
            @(negedge clk); #1;
            n_vec++; if ({busy, rsp0_valid, rsp1_valid} !== 3'b000) begin n_err++; $display("FAIL rstmid_abandoned cycle %0d got %b want 000", i, {busy, rsp0_valid, rsp1_valid}); end
        end
    endtask

    task automatic test_counter_wrap();
        @(negedge clk);
        force dut.jobs_done_q = 16'hFFFF;
        #1;
        release dut.jobs_done_q;
        #1;
        m_jobs = 16'hFFFF;
        n_vec++; if (jobs_done !== m_jobs) begin n_err++; $display("FAIL wrap_preload got %h want %h", jobs_done, m_jobs); end
        @(negedge clk);
        req1_valid = 1'b1; req1_data = rnd128(); req1_key = rnd128(); req1_mode = 1'b0;
        @(posedge clk);
        m_last = 1'b1;
        @(negedge clk); req1_valid = 1'b0;
        repeat (CW) @(negedge clk);
        #1;
        n_vec++; if (rsp1_valid !== 1'b1) begin n_err++; $display("FAIL wrap_rsp1_valid got %b want 1", rsp1_valid); end
        rsp1_ready = 1'b1;
        @(posedge clk);
        m_jobs++;
        @(negedge clk); rsp1_ready = 1'b0; #1;
        n_vec++; if (jobs_done !== 16'h0000) begin n_err++; $display("FAIL wrap_jobs_done got %h want 0000", jobs_done); end
    endtask

    // Job-level reference: a job becomes visible CW+1 cycles after acceptance and
    // leaves on the owner's ready; the chooser follows the round-robin rule.
    task automatic test_random(input int n);
        logic m_busy, m_owner, sel, e0, e1, ev0, ev1;
        int m_left;
        logic [127:0] m_exp;
        m_busy = 1'b0; m_owner = 1'b0; m_left = 0; m_exp = '0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            req0_valid = 1'($urandom_range(0, 1)); req1_valid = 1'($urandom_range(0, 1));
            req0_mode = 1'($urandom_range(0, 1)); req1_mode = 1'($urandom_range(0, 1));
            req0_data = rnd128(); req0_key = rnd128(); req1_data = rnd128(); req1_key = rnd128();
            rsp0_ready = 1'($urandom_range(0, 1)); rsp1_ready = 1'($urandom_range(0, 1));
            #1;
            sel = (req0_valid && !req1_valid) ? 1'b0 : (req1_valid && !req0_valid) ? 1'b1 : !m_last;
            e0 = !m_busy && req0_valid && !sel;
            e1 = !m_busy && req1_valid && sel;
            ev0 = m_busy && m_left == 0 && !m_owner;
            ev1 = m_busy && m_left == 0 && m_owner;
            n_vec++; if ({req0_ready, req1_ready} !== {e0, e1}) begin n_err++; $display("FAIL rnd_ready cycle %0d got %b want %b", c, {req0_ready, req1_ready}, {e0, e1}); end
            n_vec++; if ({rsp0_valid, rsp1_valid} !== {ev0, ev1}) begin n_err++; $display("FAIL rnd_rsp_valid cycle %0d got %b want %b", c, {rsp0_valid, rsp1_valid}, {ev0, ev1}); end
            n_vec++; if (busy !== m_busy) begin n_err++; $display("FAIL rnd_busy cycle %0d got %b want %b", c, busy, m_busy); end
            n_vec++; if (jobs_done !== m_jobs) begin n_err++; $display("FAIL rnd_jobs_done cycle %0d got %h want %h", c, jobs_done, m_jobs); end
            if (ev0 || ev1) begin
                n_vec++; if (rsp_data !== m_exp) begin n_err++; $display("FAIL rnd_rsp_data cycle %0d got %h want %h", c, rsp_data, m_exp); end
            end
            if (m_busy) begin
                n_vec++; if (owner !== m_owner) begin n_err++; $display("FAIL rnd_owner cycle %0d got %b want %b", c, owner, m_owner); end
            end
            if (e0 || e1) begin
                m_busy = 1'b1; m_owner = sel; m_last = sel; m_left = CW;
                m_exp = sel ? expect_result(req1_mode, req1_data, req1_key)
                            : expect_result(req0_mode, req0_data, req0_key);
            end else if (m_busy) begin
                if (m_left > 0) m_left--;
                else if (m_owner ? rsp1_ready : rsp0_ready) begin
                    m_busy = 1'b0;
                    m_jobs++;
                end
            end
        end
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fips_encrypt();
        test_decrypt();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_counter_wrap();
        test_random(400);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
